// File: rtl/exc_sched_if.sv
// Pipeline/CP0 side bundle of the exception scheduler: MEM-stage flags, CP0 state,
// stall requests in; exception code, flush, redirect PC and stall vector out.
interface exc_sched_if;
  logic        inst_valid_i;
  logic [7:0]  exc_flags_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic [31:0] excepttype_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [5:0]  stall_o;
  logic        busy_o;

  modport master (
    output inst_valid_i, exc_flags_i, status_i, cause_i, epc_i,
           stallreq_id_i, stallreq_ex_i,
    input  excepttype_o, flush_o, new_pc_o, stall_o, busy_o
  );

  modport slave (
    input  inst_valid_i, exc_flags_i, status_i, cause_i, epc_i,
           stallreq_id_i, stallreq_ex_i,
    output excepttype_o, flush_o, new_pc_o, stall_o, busy_o
  );
endinterface

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler: fixed-priority event pick, pipeline flush and
// PC redirect, post-flush interrupt holdoff and stall arbitration.
module exc_sched #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int unsigned INT_HOLDOFF = 2
) (
  input logic       clk,
  input logic       rst,
  exc_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLUSHED, HOLD} state_t;

  state_t      state;
  logic [3:0]  holdoff;
  logic        int_req;
  logic        take;
  logic        eret_win;
  logic [7:0]  flags;
  logic [31:0] code;

  always_comb begin
    int_req = bus.status_i[0] & ~bus.status_i[1]
            & (|(bus.cause_i[15:8] & bus.status_i[15:8]))
            & bus.inst_valid_i & (holdoff == '0);
    flags    = bus.inst_valid_i ? bus.exc_flags_i : '0;
    code     = '0;
    eret_win = 1'b0;
    if (int_req)       code = 32'h1;
    else if (flags[0]) code = 32'h4;
    else if (flags[1]) code = 32'hA;
    else if (flags[2]) code = 32'hC;
    else if (flags[3]) code = 32'hD;
    else if (flags[4]) code = 32'h8;
    else if (flags[5]) code = 32'h9;
    else if (flags[6]) code = 32'h5;
    else if (flags[7]) begin
      code     = 32'hE;
      eret_win = 1'b1;
    end
    // FLUSHED ignores all inputs; reset silences every output
    take = (code != '0) && (state != FLUSHED) && !rst;
  end

  always_comb begin
    bus.excepttype_o = take ? code : '0;
    bus.flush_o      = take;
    bus.new_pc_o     = take ? (eret_win ? bus.epc_i : EXC_VECTOR) : '0;
    bus.busy_o       = !rst && (state != IDLE);
    if (rst || take || state == FLUSHED) bus.stall_o = '0;
    else if (bus.stallreq_ex_i)          bus.stall_o = 6'b001111;
    else if (bus.stallreq_id_i)          bus.stall_o = 6'b000111;
    else                                 bus.stall_o = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      holdoff <= '0;
    end else begin
      unique case (state)
        IDLE: if (take) state <= FLUSHED;
        FLUSHED: begin
          holdoff <= 4'(INT_HOLDOFF);
          state   <= (INT_HOLDOFF > 0) ? HOLD : IDLE;
        end
        HOLD: begin
          if (take) begin
            state <= FLUSHED;
          end else begin
            holdoff <= holdoff - 4'd1;
            if (holdoff == 4'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0]};

endmodule

// File: tb/tb_exc_sched.sv
// Scoreboard bench for exc_sched: driver pushes model expectations, monitor checks.
module tb_exc_sched;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          H   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exc_sched_if bus();

  exc_sched #(.EXC_VECTOR(VEC), .INT_HOLDOFF(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] code;
    logic        flush;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Model state: cycle index and the cycle of the most recent flush.
  int cyc = 0;
  int last_flush = -1000;
  int unsigned codes [8] = '{32'h4, 32'hA, 32'hC, 32'hD, 32'h8, 32'h9, 32'h5, 32'hE};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] f,
                      input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                      input logic sid, input logic sex, input string tag);
    exp_t e;
    int d;
    logic ireq;
    logic [7:0] fl;
    int win;
    @(posedge clk);
    #1;
    rst = r;
    bus.inst_valid_i = v; bus.exc_flags_i = f; bus.status_i = st;
    bus.cause_i = ca; bus.epc_i = ep; bus.stallreq_id_i = sid; bus.stallreq_ex_i = sex;
    e.tag = tag; e.code = '0; e.flush = 1'b0; e.pc = '0; e.stall = '0; e.busy = 1'b0;
    d = cyc - last_flush;
    if (r) begin
      last_flush = -1000;
    end else if (d == 1) begin
      e.busy = 1'b1;
    end else begin
      ireq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0) && v && (d > 1 + H);
      fl = v ? f : 8'h00;
      win = -1;
      if (ireq) e.code = 32'h1;
      else begin
        for (int i = 0; i < 8; i++)
          if (win < 0 && fl[i]) begin
            win = i;
            e.code = codes[i];
          end
      end
      e.flush = (e.code != 0);
      e.pc = (win == 7) ? ep : VEC;
      e.stall = e.flush ? 6'h00 : sex ? 6'h0F : sid ? 6'h07 : 6'h00;
      e.busy = (d <= 1 + H);
      if (e.flush) last_flush = cyc;
    end
    cyc++;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 1, 8'h00, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".code"},  bus.excepttype_o, e.code);
        chk({e.tag, ".flush"}, 32'(bus.flush_o), 32'(e.flush));
        if (e.flush) chk({e.tag, ".pc"}, bus.new_pc_o, e.pc);
        chk({e.tag, ".stall"}, 32'(bus.stall_o), 32'(e.stall));
        chk({e.tag, ".busy"},  32'(bus.busy_o), 32'(e.busy));
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    bus.inst_valid_i = 1'b1; bus.exc_flags_i = 8'hFF; bus.status_i = '0;
    bus.cause_i = '0; bus.epc_i = '0; bus.stallreq_id_i = 1'b0; bus.stallreq_ex_i = 1'b0;

    step(1, 1, 8'hFF, 0, 0, 0, 1, 1, "reset");
    step(1, 1, 8'hFF, 0, 0, 0, 1, 1, "reset");
    idle(1, "after_reset");
    step(0, 1, 8'h10, 0, 0, 0, 0, 0, "syscall");
    idle(4, "post_syscall");
    step(0, 1, 8'h80, 0, 0, 32'h80001234, 0, 0, "eret");
    idle(4, "post_eret");
    step(0, 1, 8'h04, 32'h0000FF01, 32'h00000400, 0, 0, 0, "int_pri");
    idle(4, "post_int");
    step(0, 1, 8'h04, 32'h0000FF03, 32'h00000400, 0, 0, 0, "ov_pri");
    idle(4, "post_ov");
    for (int i = 0; i < 6; i++)
      step(0, 1, 8'h00, 32'h0000FF01, 32'h00000400, 0, 0, 0, "holdoff");
    step(0, 1, 8'h02, 32'h0000FF01, 32'h00000400, 0, 0, 0, "ri_hold");
    idle(4, "post_ri");
    step(0, 1, 8'h00, 0, 0, 0, 0, 1, "stall_ex");
    step(0, 1, 8'h00, 0, 0, 0, 1, 0, "stall_id");
    step(0, 1, 8'h01, 0, 0, 0, 1, 1, "stall_adel");
    idle(4, "post_adel");
    step(0, 0, 8'h3F, 32'h0000FF01, 32'h00000400, 0, 0, 0, "bubble");
    step(0, 1, 8'h10, 0, 0, 0, 0, 0, "sys2");
    idle(2, "into_hold");
    step(1, 1, 8'h00, 0, 0, 0, 0, 0, "rst_hold");
    idle(1, "after_rst_hold");

    for (int n = 0; n < 600; n++) begin
      logic [7:0]  f;
      logic [31:0] st, ca;
      f  = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
           ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      st = {$urandom} & 32'h0000FF03;
      ca = ($urandom_range(0, 1) == 0) ? ({$urandom} & 32'h0000FF00) : 32'h0;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0, f, st, ca, $urandom,
           $urandom_range(0, 1), $urandom_range(0, 3) == 0, "rand");
    end

    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exc_sched.md
Name: exc_sched

Overview:
- Exception and interrupt scheduler for the MIPS32 pipeline, placed beside the CP0 register file.
- Each cycle it takes the exception flags of the instruction in the MEM stage and the pending-interrupt state.
- It picks one winning event by fixed priority and drives the CP0 exception-type code.
- It flushes the pipeline, redirects the PC, and arbitrates the per-stage stall requests.

Parameters:
- EXC_VECTOR, 32'hBFC00380, target PC for every exception except eret.
- INT_HOLDOFF, 2, cycles after a flush during which interrupts are not accepted (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inst_valid_i  in  1  MEM stage holds a real instruction (not a bubble)
- exc_flags_i  in  8  {eret, ades, break, syscall, trap, ov, ri, adel}, bit7..bit0
- status_i  in  32  forwarded CP0 Status
- cause_i  in  32  forwarded CP0 Cause
- epc_i  in  32  forwarded CP0 EPC
- stallreq_id_i  in  1  ID stage stall request
- stallreq_ex_i  in  1  EX stage stall request (multicycle divide)
- excepttype_o  out  32  exception code to CP0 (0 = none)
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect PC, valid while flush_o=1
- stall_o  out  6  {wb,mem,ex,id,if,pc} stall vector
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, holdoff counter=0.
- While rst=1, all outputs are held at 0: excepttype_o=0, flush_o=0, new_pc_o=0, stall_o=0, busy_o=0.
- Interrupt pending: int_req = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]) & inst_valid_i & (holdoff==0).
- Priority, highest first, each with its excepttype_o code:
  - interrupt, 32'h1
  - adel, 32'h4
  - ri, 32'hA
  - ov, 32'hC
  - trap, 32'hD
  - syscall, 32'h8
  - break, 32'h9
  - ades, 32'h5
  - eret, 32'hE
- exc_flags_i is honoured only when inst_valid_i=1.
- excepttype_o, flush_o and new_pc_o are combinational in IDLE, so CP0 latches the code in the same cycle.
- new_pc_o = epc_i for eret and EXC_VECTOR for all other events.
- FSM states:
  - IDLE: when any event wins, assert flush_o and go to FLUSHED.
  - FLUSHED: excepttype_o=0, flush_o=0, inputs ignored; load holdoff with INT_HOLDOFF; go to HOLD if INT_HOLDOFF>0, else IDLE.
  - HOLD: synchronous exceptions are accepted exactly as in IDLE; interrupts are masked while holdoff!=0.
  - HOLD counting: holdoff decrements each cycle; return to IDLE when it reaches 1→0.
  - HOLD with an accepted exception: go to FLUSHED, which reloads holdoff.
- busy_o=1 in FLUSHED and HOLD.
- Stall arbitration:
  - stallreq_ex_i → 6'b001111.
  - else stallreq_id_i → 6'b000111.
  - else 6'b000000.
  - Forced to 0 whenever flush_o=1 or state=FLUSHED; flush beats stall.
- Simultaneous events: an interrupt together with a synchronous flag takes the interrupt (code 1); the instruction is replayed after eret.
- Event coinciding with a stall: the event is taken and stall_o=0 that cycle.
- Reset during FLUSHED or HOLD: return to IDLE next edge, holdoff cleared.

Test Plan:
- Reset: rst=1 for 2 cycles with exc_flags_i=8'hFF → excepttype_o=0, flush_o=0, stall_o=0; after release state=IDLE, busy_o=0.
- Syscall: inst_valid_i=1, exc_flags_i=8'h10 → same cycle excepttype_o=32'h8, flush_o=1, new_pc_o=32'hBFC00380; next cycle flush_o=0, busy_o=1; busy_o=0 after 1+INT_HOLDOFF cycles.
- Eret: epc_i=32'h80001234, exc_flags_i=8'h80 → excepttype_o=32'hE, new_pc_o=32'h80001234.
- Priority: status_i=32'h0000FF01, cause_i[15:8]=8'h04, exc_flags_i=8'h04 → excepttype_o=32'h1; repeat with status_i[1]=1 → excepttype_o=32'hC.
- Holdoff: interrupt pending continuously, INT_HOLDOFF=2 → first flush, then no flush for 3 cycles (FLUSHED+2 HOLD), second flush on cycle 4; a ri flag during HOLD → immediate flush, code 32'hA.
- Stall: stallreq_ex_i=1 → stall_o=6'b001111; stallreq_id_i=1 only → 6'b000111; stallreq_ex_i=1 plus adel → stall_o=0, excepttype_o=32'h4.
